// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the data-memory access controller.
package mips_mem_pkg;

  localparam int unsigned DW              = 32;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned DEF_WAIT_STATES = 2;
  localparam int unsigned DEF_MAX_STREAK  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_DATA  = 1'b0,
    GNT_FETCH = 1'b1
  } gnt_t;

  // Request attributes latched at grant time and held for the whole access.
  typedef struct packed {
    gnt_t            gnt;
    logic            we;
    logic [DW-1:0]   wdata;
  } req_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Requester (data + fetch) and memory-side signals of the access controller.
interface dmem_access_ctrl_if
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW = 32
);

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  // Controller side.
  modport slave (
    input  d_req, d_we, d_addr, d_wdata, i_req, i_addr, m_rdata,
    output d_rdata, d_ready, i_rdata, i_ready, m_en, m_we, m_addr, m_wdata
  );

  // Pipeline + memory model side.
  modport master (
    output d_req, d_we, d_addr, d_wdata, i_req, i_addr, m_rdata,
    input  d_rdata, d_ready, i_rdata, i_ready, m_en, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority data-over-fetch arbiter with a streak guard against fetch starvation.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_req,
  input  logic i_req,
  input  logic grant_en,
  output gnt_t gnt_c
);

  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_STREAK);

  logic [CNT_W-1:0] streak_q;

  // Fetch wins when alone, or when data has used up its streak allowance.
  always_comb begin
    gnt_c = GNT_DATA;
    if (i_req && !d_req) begin
      gnt_c = GNT_FETCH;
    end else if (i_req && d_req && (streak_q == STREAK_MAX)) begin
      gnt_c = GNT_FETCH;
    end
  end

  // Counts data grants that made a pending fetch wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= '0;
    end else if (grant_en) begin
      if ((gnt_c == GNT_DATA) && i_req) begin
        if (streak_q < STREAK_MAX) begin
          streak_q <= streak_q + CNT_W'(1);
        end
      end else begin
        streak_q <= '0;
      end
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares a single-port multi-cycle data memory between the MEM-stage and fetch ports.
module dmem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
  parameter int unsigned MAX_STREAK  = DEF_MAX_STREAK
) (
  input  logic               clk,
  input  logic               reset_n,
  dmem_access_ctrl_if.slave  bus,
  output logic               busy
);

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  req_t             req_q;
  logic [AW-1:0]    addr_q;

  gnt_t             gnt_c;
  logic             start_c;
  logic             last_c;
  logic             d_cap_c;
  logic             i_cap_c;

  req_t             sel_req;
  logic [AW-1:0]    sel_addr;
  logic             m_en_nxt;
  logic             m_we_nxt;
  logic [AW-1:0]    m_addr_nxt;
  logic [DW-1:0]    m_wdata_nxt;
  logic             d_ready_nxt;
  logic             i_ready_nxt;
  logic             busy_nxt;

  assign start_c = (state_q == IDLE) && (bus.d_req || bus.i_req);
  assign last_c  = (state_q == ACCESS) && (cnt_q == '0);
  assign d_cap_c = last_c && (req_q.gnt == GNT_DATA) && !req_q.we;
  assign i_cap_c = last_c && (req_q.gnt == GNT_FETCH);

  mem_port_arbiter #(
    .MAX_STREAK (MAX_STREAK)
  ) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .d_req    (bus.d_req),
    .i_req    (bus.i_req),
    .grant_en (start_c),
    .gnt_c    (gnt_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start_c) state_nxt = ACCESS;
      ACCESS:  if (cnt_q == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs, keyed on the next state.
  always_comb begin
    sel_req  = req_q;
    sel_addr = addr_q;
    if (state_q == IDLE) begin
      sel_req.gnt   = gnt_c;
      sel_req.we    = (gnt_c == GNT_DATA) ? bus.d_we : 1'b0;
      sel_req.wdata = bus.d_wdata;
      sel_addr      = (gnt_c == GNT_DATA) ? bus.d_addr : bus.i_addr;
    end

    m_en_nxt    = (state_nxt == ACCESS);
    m_we_nxt    = m_en_nxt && (sel_req.gnt == GNT_DATA) && sel_req.we;
    m_addr_nxt  = m_en_nxt ? sel_addr : '0;
    m_wdata_nxt = m_en_nxt ? sel_req.wdata : '0;
    d_ready_nxt = (state_nxt == RESP) && (req_q.gnt == GNT_DATA);
    i_ready_nxt = (state_nxt == RESP) && (req_q.gnt == GNT_FETCH);
    busy_nxt    = (state_nxt != IDLE);
  end

  // Wait counter and latched request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      req_q  <= '0;
      addr_q <= '0;
    end else if (start_c) begin
      cnt_q  <= CNT_W'(WAIT_STATES);
      req_q  <= sel_req;
      addr_q <= sel_addr;
    end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  // Registered outputs and read-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.m_en    <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.d_ready <= 1'b0;
      bus.i_ready <= 1'b0;
      bus.d_rdata <= '0;
      bus.i_rdata <= '0;
      busy        <= 1'b0;
    end else begin
      bus.m_en    <= m_en_nxt;
      bus.m_we    <= m_we_nxt;
      bus.m_addr  <= m_addr_nxt;
      bus.m_wdata <= m_wdata_nxt;
      bus.d_ready <= d_ready_nxt;
      bus.i_ready <= i_ready_nxt;
      busy        <= busy_nxt;
      if (d_cap_c) bus.d_rdata <= bus.m_rdata;
      if (i_cap_c) bus.i_rdata <= bus.m_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed, table-driven bench for dmem_access_ctrl (WAIT_STATES=2 and WAIT_STATES=0 instances).
module tb_dmem_access_ctrl;
  import mips_mem_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned WS = 2;
  localparam int unsigned MS = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic rst0_n;
  logic busy;
  logic busy0;

  dmem_access_ctrl_if #(.AW(AW)) bus  ();
  dmem_access_ctrl_if #(.AW(AW)) bus0 ();

  dmem_access_ctrl #(.AW(AW), .WAIT_STATES(WS), .MAX_STREAK(MS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  dmem_access_ctrl #(.AW(AW), .WAIT_STATES(0), .MAX_STREAK(4)) dut0 (
    .clk     (clk),
    .reset_n (rst0_n),
    .bus     (bus0),
    .busy    (busy0)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] m_rdata;
    logic        exp_fetch;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_d_rdata;
    logic [31:0] exp_i_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic d_req, input logic d_we,
                              input logic [31:0] d_addr, input logic [31:0] d_wdata,
                              input logic i_req, input logic [31:0] i_addr,
                              input logic [31:0] m_rdata, input logic exp_fetch,
                              input logic [31:0] exp_addr, input logic exp_we,
                              input logic [31:0] exp_d, input logic [31:0] exp_i);
    vec_t v;
    v.name = name;           v.d_req = d_req;       v.d_we = d_we;
    v.d_addr = d_addr;       v.d_wdata = d_wdata;   v.i_req = i_req;
    v.i_addr = i_addr;       v.m_rdata = m_rdata;   v.exp_fetch = exp_fetch;
    v.exp_addr = exp_addr;   v.exp_we = exp_we;     v.exp_d_rdata = exp_d;
    v.exp_i_rdata = exp_i;
    return v;
  endfunction

  // One complete access on the WAIT_STATES=2 instance, started from IDLE.
  task automatic run_txn(input vec_t v);
    int   cyc = 0;
    int   en  = 0;
    logic addr_ok = 1'b1;
    logic we_ok   = 1'b1;
    logic wd_ok   = 1'b1;
    logic done    = 1'b0;
    bus.d_req   = v.d_req;   bus.d_we   = v.d_we;
    bus.d_addr  = v.d_addr;  bus.d_wdata = v.d_wdata;
    bus.i_req   = v.i_req;   bus.i_addr = v.i_addr;
    bus.m_rdata = v.m_rdata;
    while (!done && cyc < 20) begin
      step();
      cyc++;
      if (bus.m_en) begin
        en++;
        if (bus.m_addr !== v.exp_addr) addr_ok = 1'b0;
        if (bus.m_we !== v.exp_we) we_ok = 1'b0;
        if (v.exp_we && bus.m_wdata !== v.d_wdata) wd_ok = 1'b0;
      end else if (bus.m_we) begin
        we_ok = 1'b0;
      end
      if (bus.d_ready || bus.i_ready) done = 1'b1;
    end
    check({v.name, " latency"}, 32'(cyc), 32'(WS + 2));
    check({v.name, " m_en cycles"}, 32'(en), 32'(WS + 1));
    check({v.name, " m_addr"}, 32'(addr_ok), 32'd1);
    check({v.name, " m_we"}, 32'(we_ok), 32'd1);
    check({v.name, " m_wdata"}, 32'(wd_ok), 32'd1);
    check({v.name, " i_ready"}, 32'(bus.i_ready), 32'(v.exp_fetch));
    check({v.name, " d_ready"}, 32'(bus.d_ready), 32'(!v.exp_fetch));
    check({v.name, " busy in RESP"}, 32'(busy), 32'd1);
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    step();
    check({v.name, " ready width"}, 32'(bus.d_ready | bus.i_ready), 32'd0);
    check({v.name, " busy idle"}, 32'(busy), 32'd0);
    check({v.name, " d_rdata"}, bus.d_rdata, v.exp_d_rdata);
    check({v.name, " i_rdata"}, bus.i_rdata, v.exp_i_rdata);
  endtask

  initial begin
    int          times[6];
    logic [5:0]  order;
    int          npulse;
    int          cyc;
    int          en;
    int          last;

    vecs[0] = mk("load40",   1, 0, 32'h40,       32'h0,        0, 32'h0,   32'hDEADBEEF,
                 0, 32'h40,       0, 32'hDEADBEEF, 32'h0);
    vecs[1] = mk("store80",  1, 1, 32'h80,       32'h12345678, 0, 32'h0,   32'hAAAA5555,
                 0, 32'h80,       1, 32'hDEADBEEF, 32'h0);
    vecs[2] = mk("fetch100", 0, 1, 32'h999,      32'h5A5A5A5A, 1, 32'h100, 32'hCAFEF00D,
                 1, 32'h100,      0, 32'hDEADBEEF, 32'hCAFEF00D);
    vecs[3] = mk("loadtop",  1, 0, 32'hFFFFFFFC, 32'h0,        0, 32'h0,   32'h01020304,
                 0, 32'hFFFFFFFC, 0, 32'h01020304, 32'hCAFEF00D);
    vecs[4] = mk("fetch104", 0, 0, 32'h0,        32'h0,        1, 32'h104, 32'h55AA55AA,
                 1, 32'h104,      0, 32'h01020304, 32'h55AA55AA);

    bus.d_req = 0;  bus.d_we = 0;  bus.d_addr = '0;  bus.d_wdata = '0;
    bus.i_req = 0;  bus.i_addr = '0;  bus.m_rdata = '0;
    bus0.d_req = 0; bus0.d_we = 0; bus0.d_addr = '0; bus0.d_wdata = '0;
    bus0.i_req = 0; bus0.i_addr = '0; bus0.m_rdata = '0;
    reset_n = 1'b0;
    rst0_n  = 1'b0;

    step();
    check("rst m_en", 32'(bus.m_en), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ready", 32'(bus.d_ready | bus.i_ready), 32'd0);
    check("rst d_rdata", bus.d_rdata, 32'h0);
    check("rst i_rdata", bus.i_rdata, 32'h0);
    check("rst m_addr", bus.m_addr, 32'h0);
    check("rst busy0", 32'(busy0), 32'd0);
    #2;
    reset_n = 1'b1;
    rst0_n  = 1'b1;
    step();

    foreach (vecs[k]) run_txn(vecs[k]);

    // Both requesters held: expect data, data, fetch repeating, every WS+3 cycles.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    bus.i_req = 1; bus.i_addr = 32'h400; bus.m_rdata = 32'h11112222;
    order  = '0;
    npulse = 0;
    cyc    = 0;
    while (npulse < 6 && cyc < 60) begin
      step();
      cyc++;
      if (bus.d_ready || bus.i_ready) begin
        check("streak exclusive ready", 32'(bus.d_ready ^ bus.i_ready), 32'd1);
        order[npulse] = bus.i_ready;
        times[npulse] = cyc;
        npulse++;
        if (npulse == 6) begin
          bus.d_req = 0;
          bus.i_req = 0;
        end
      end
    end
    check("streak pulse count", 32'(npulse), 32'd6);
    check("streak grant order", 32'(order), 32'b100100);
    check("streak first latency", 32'(times[0]), 32'(WS + 2));
    for (int k = 1; k < 6; k++) begin
      if (k < npulse) check("streak spacing", 32'(times[k] - times[k-1]), 32'(WS + 3));
    end
    step();
    check("streak idle", 32'(busy), 32'd0);
    check("streak d_rdata", bus.d_rdata, 32'h11112222);
    check("streak i_rdata", bus.i_rdata, 32'h11112222);

    // Reset during the second ACCESS cycle of a store, then restart with req held.
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hA5A5F00F;
    bus.m_rdata = 32'h77778888;
    step();
    step();
    check("pre-reset m_en", 32'(bus.m_en), 32'd1);
    check("pre-reset m_we", 32'(bus.m_we), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("async m_en", 32'(bus.m_en), 32'd0);
    check("async m_we", 32'(bus.m_we), 32'd0);
    check("async busy", 32'(busy), 32'd0);
    check("async d_rdata", bus.d_rdata, 32'h0);
    @(posedge clk);
    #1;
    check("in-reset ready", 32'(bus.d_ready | bus.i_ready), 32'd0);
    check("in-reset m_en", 32'(bus.m_en), 32'd0);
    #2 reset_n = 1'b1;
    cyc = 0;
    en  = 0;
    while (!bus.d_ready && cyc < 20) begin
      step();
      cyc++;
      if (bus.m_en) en++;
    end
    check("restart latency", 32'(cyc), 32'(WS + 2));
    check("restart m_en cycles", 32'(en), 32'(WS + 1));
    bus.d_req = 0;
    step();
    check("restart store d_rdata", bus.d_rdata, 32'h0);

    // Zero wait states: single m_en cycle, ready two cycles after request, period 3.
    bus0.d_req = 1; bus0.d_we = 0; bus0.d_addr = 32'h10; bus0.m_rdata = 32'h0BADF00D;
    cyc = 0;
    en  = 0;
    while (!bus0.d_ready && cyc < 20) begin
      step();
      cyc++;
      if (bus0.m_en) begin
        en++;
        check("ws0 m_addr", bus0.m_addr, 32'h10);
      end
    end
    check("ws0 latency", 32'(cyc), 32'd2);
    check("ws0 m_en cycles", 32'(en), 32'd1);
    check("ws0 d_rdata", bus0.d_rdata, 32'h0BADF00D);
    last = 0;
    for (int r = 0; r < 2; r++) begin
      cyc = 0;
      bus0.m_rdata = 32'h0BADF00D + 32'(r + 1);
      do begin
        step();
        cyc++;
      end while (!bus0.d_ready && cyc < 20);
      check("ws0 period", 32'(cyc), 32'd3);
      check("ws0 b2b d_rdata", bus0.d_rdata, 32'h0BADF00D + 32'(r + 1));
      last = r;
    end
    bus0.d_req = 0;
    step();
    check("ws0 idle", 32'(busy0), 32'd0);
    check("ws0 i_ready", 32'(bus0.i_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences a single-port, multi-cycle data memory and shares it between two requesters: the MEM-stage load/store port (d_*) and the instruction-fetch port (i_*).
- Inserts a parameterised number of wait states and returns read data with a one-cycle ready pulse; the pipeline uses the not-ready condition to stall.
- Arbitration is fixed priority (data over fetch) with a starvation guard for fetch.
- Sits between the MEM/IF stages and the data memory unit.

Parameters:
- AW, 32, address width of both ports and memory.
- WAIT_STATES, 2, extra cycles m_en is held before m_rdata is valid (0..15).
- MAX_STREAK, 4, consecutive data grants allowed while i_req pends before fetch is forced (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- d_req  in  1  MEM-stage access request; held until d_ready.
- d_we  in  1  1=store, 0=load; stable while d_req.
- d_addr  in  AW  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data, valid when d_ready.
- d_ready  out  1  one-cycle completion pulse (loads and stores).
- i_req  in  1  fetch request; held until i_ready.
- i_addr  in  AW  fetch address.
- i_rdata  out  32  fetched word, valid when i_ready.
- i_ready  out  1  one-cycle completion pulse.
- m_en  out  1  memory enable.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; d_rdata and i_rdata 0; wait counter, streak counter and grant register cleared. Reset mid-access aborts the access immediately: no ready pulse, and m_en/m_we drop asynchronously.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If d_req or i_req, arbitrate, then latch grant, addr, we and wdata into registers.
  - Load wait counter with WAIT_STATES and go to ACCESS.
  - Outputs are idle in this state; no combinational request-to-memory path.
- Arbitration:
  - Only d_req: grant data.
  - Only i_req: grant fetch.
  - Both: grant fetch if streak==MAX_STREAK, otherwise grant data.
- Streak counter:
  - Increments on a data grant while i_req=1, saturating at MAX_STREAK.
  - Clears on any fetch grant, and on a data grant while i_req=0.
- ACCESS:
  - m_en=1; m_addr and m_wdata come from the latched registers.
  - m_we = latched we, and only when the grant is data. Fetch never writes.
  - Counter decrements each cycle. On the cycle the counter==0, m_rdata is sampled into d_rdata or i_rdata (loads and fetches only), then go to RESP.
  - ACCESS lasts WAIT_STATES+1 cycles.
- RESP:
  - The granted port's ready=1 for exactly one cycle; the other ready stays 0; m_en=0. Then go to IDLE unconditionally.
  - Requesters deassert req (or present the next request) on the edge after ready. A req still high in IDLE is a new access.
- d_rdata/i_rdata hold their value until the next load or fetch completes on that port; stores leave d_rdata unchanged.
- Latency: req sampled in IDLE at edge N, then ACCESS N+1..N+1+WAIT_STATES, then ready at cycle N+2+WAIT_STATES. Back-to-back accesses issue every WAIT_STATES+3 cycles.
- A requester that drops req mid-access (protocol violation) does not abort; the access completes and ready still pulses.
- Addresses pass unmodified; no alignment checking.

Decomposition:
- Shared package (mips_mem_pkg): state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2); grant encoding (GNT_DATA=1'b0, GNT_FETCH=1'b1); default WAIT_STATES/MAX_STREAK constants.
- One natural sub-module, mem_port_arbiter: combinational grant selection plus the streak counter. FSM, wait counter and datapath registers stay in the top.

Test Plan:
- WAIT_STATES=2: d_req=1, d_we=0, d_addr=0x40, m_rdata=0xDEADBEEF -> m_en high 3 cycles with m_addr=0x40, m_we=0; d_ready pulses 4 cycles after req sampled; d_rdata=0xDEADBEEF; i_ready stays 0.
- Store: d_we=1, d_addr=0x80, d_wdata=0x12345678 -> m_we=1 for 3 cycles with m_wdata=0x12345678; d_ready one pulse; d_rdata keeps its previous value.
- Simultaneous d_req and i_req held continuously, MAX_STREAK=2 -> grant order data, data, fetch, data, data, fetch; each grant spaced 5 cycles.
- Fetch-only i_req with i_addr=0x100 while d_we=1 is asserted without d_req -> m_we stays 0 throughout; i_rdata is captured from m_rdata.
- reset_n pulled low in the second ACCESS cycle -> m_en=0 immediately, no ready pulse, busy=0. After release, a held d_req restarts the access from IDLE with full latency.
- WAIT_STATES=0 -> m_en high 1 cycle; ready 2 cycles after request; back-to-back period 3 cycles.
